// File: rtl/byte_pack_glue.sv
// Byte-stream packer: variable-width byte beats packed into NB-byte words, queued in an output FIFO.
// Latency: a completed word is visible on out_data the cycle after its input beat (FIFO empty).
// Backpressure: in_ready drops in TAIL or when the FIFO cannot take a full word plus a tail word.

// Small FWFT FIFO with registered occupancy and almost-full flag.
// Latency: a push is visible at the head one edge later when empty.
// Backpressure: pushes into a full FIFO are refused; pops of an empty FIFO are ignored.
module pack_fifo #(
    parameter int W         = 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = 4
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop_rdy,
    output logic [W-1:0]               head_dat,
    output logic                       head_vld,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       afull
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          afull_q, afull_d;
    logic          do_push, do_pop;

    // Pointer, occupancy and almost-full next-state.
    always_comb begin
        do_push  = push_vld && (count_q != CW'(DEPTH));
        do_pop   = pop_rdy && (count_q != '0);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
        afull_d = int'(count_d) >= AFULL_LVL;
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            afull_q  <= afull_d;
        end
    end

    // Head is forced to zero when empty so stale array contents never leak out.
    always_comb begin
        head_vld = (count_q != '0);
        head_dat = head_vld ? mem_q[rd_ptr_q] : '0;
        count    = count_q;
        afull    = afull_q;
    end
endmodule

module byte_pack_glue #(
    parameter int NB        = 4,
    parameter int DEPTH     = 512,
    parameter int AFULL_LVL = 256,
    parameter int SWAP      = 0
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic [8*NB-1:0]            in_data,
    input  logic [$clog2(NB+1)-1:0]    in_nbytes,
    input  logic                       in_valid,
    input  logic                       in_flush,
    output logic                       in_ready,
    output logic [8*NB-1:0]            out_data,
    output logic [$clog2(NB+1)-1:0]    out_nbytes,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       afull
);
    localparam int NBW = $clog2(NB + 1);
    localparam int LW  = $clog2(NB);
    localparam int ACC = 2 * NB - 1;

    typedef enum logic {RUN = 1'b0, TAIL = 1'b1} state_e;

    typedef struct packed {
        logic [8*NB-1:0] dat;
        logic [NBW-1:0]  nbytes;
        logic            last;
    } word_t;

    state_e                  state_q, state_d;
    logic [LW-1:0]           level_q, level_d;
    logic [ACC-1:0][7:0]     acc_q, acc_d;
    logic [ACC-1:0][7:0]     comb;
    logic [NB-1:0][7:0]      in_bytes;
    logic [NB-1:0][7:0]      wb;
    logic                    push;
    word_t                   push_word, head;
    int                      n_beat, total;

    assign in_bytes = in_data;

    // Room is kept for a full word plus the tail word a flush may generate.
    always_comb begin
        in_ready = (state_q == RUN) && (int'(fifo_count) <= DEPTH - 2);
    end

    // Merge the beat into the accumulator, decide pushes, and sequence RUN/TAIL.
    // Accumulator bytes at or above the level are kept zero, so padding is free.
    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        acc_d     = acc_q;
        push      = 1'b0;
        push_word = '0;
        wb        = '0;
        n_beat    = 0;
        if (in_valid) begin
            n_beat = (int'(in_nbytes) > NB) ? NB : int'(in_nbytes);
        end
        total = int'(level_q) + n_beat;
        for (int i = 0; i < ACC; i++) begin
            comb[i] = (i < int'(level_q)) ? acc_q[i] : 8'h00;
            for (int j = 0; j < NB; j++) begin
                if (j < n_beat && i == int'(level_q) + j) begin
                    comb[i] = in_bytes[j];
                end
            end
        end

        if (state_q == TAIL) begin
            // Emit the leftover from a flush that also completed a word.
            for (int k = 0; k < NB; k++) wb[k] = acc_q[k];
            push             = 1'b1;
            push_word.nbytes = NBW'(level_q);
            push_word.last   = 1'b1;
            level_d          = '0;
            acc_d            = '0;
            state_d          = RUN;
        end else if (in_ready && (in_valid || in_flush)) begin
            if (total >= NB) begin
                for (int k = 0; k < NB; k++) wb[k] = comb[k];
                push             = 1'b1;
                push_word.nbytes = NBW'(NB);
                push_word.last   = in_flush && (total == NB);
                acc_d            = '0;
                for (int k = 0; k < NB - 1; k++) acc_d[k] = comb[k + NB];
                level_d          = LW'(total - NB);
                if (in_flush && total > NB) state_d = TAIL;
            end else if (in_flush) begin
                // Partial word, or a zero-byte marker when nothing is held.
                for (int k = 0; k < NB; k++) wb[k] = comb[k];
                push             = 1'b1;
                push_word.nbytes = NBW'(total);
                push_word.last   = 1'b1;
                level_d          = '0;
                acc_d            = '0;
            end else begin
                acc_d   = comb;
                level_d = LW'(total);
            end
        end

        for (int k = 0; k < NB; k++) begin
            push_word.dat[8*k +: 8] = (SWAP != 0) ? wb[NB-1-k] : wb[k];
        end
    end

    // Accumulator and state registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= RUN;
            level_q <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            acc_q   <= acc_d;
        end
    end

    pack_fifo #(
        .W         ($bits(word_t)),
        .DEPTH     (DEPTH),
        .AFULL_LVL (AFULL_LVL)
    ) u_fifo (
        .clk      (clk),
        .rstN     (rstN),
        .push_vld (push),
        .push_dat (push_word),
        .pop_rdy  (out_ready),
        .head_dat (head),
        .head_vld (out_valid),
        .count    (fifo_count),
        .afull    (afull)
    );

    assign out_data   = head.dat;
    assign out_nbytes = head.nbytes;
    assign out_last   = head.last;
endmodule

// File: tb/tb_byte_pack_glue.sv
// Bench for byte_pack_glue: directed scenarios plus a randomized stream against a byte-queue model.
// Latency: n/a (testbench).
// Backpressure: exercised through a small FIFO and random out_ready.
module tb_byte_pack_glue;
    logic        clk = 1'b0;
    logic        rstN;
    logic [31:0] in_data;
    logic [2:0]  in_nbytes;
    logic        in_valid, in_flush, in_ready;
    logic [31:0] out_data;
    logic [2:0]  out_nbytes;
    logic        out_last, out_valid, out_ready;
    logic [3:0]  fifo_count;
    logic        afull;

    logic [31:0] s_in_data;
    logic [2:0]  s_in_nbytes;
    logic        s_in_valid, s_in_flush, s_in_ready;
    logic [31:0] s_out_data;
    logic [2:0]  s_out_nbytes;
    logic        s_out_last, s_out_valid, s_out_ready;
    logic [3:0]  s_fifo_count;
    logic        s_afull;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] d;
        int          nb;
        bit          last;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  pend[$];

    byte_pack_glue #(.NB(4), .DEPTH(8), .AFULL_LVL(5), .SWAP(0)) dut (
        .clk(clk), .rstN(rstN), .in_data(in_data), .in_nbytes(in_nbytes),
        .in_valid(in_valid), .in_flush(in_flush), .in_ready(in_ready),
        .out_data(out_data), .out_nbytes(out_nbytes), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .fifo_count(fifo_count),
        .afull(afull)
    );

    byte_pack_glue #(.NB(4), .DEPTH(8), .AFULL_LVL(5), .SWAP(1)) dut_s (
        .clk(clk), .rstN(rstN), .in_data(s_in_data), .in_nbytes(s_in_nbytes),
        .in_valid(s_in_valid), .in_flush(s_in_flush), .in_ready(s_in_ready),
        .out_data(s_out_data), .out_nbytes(s_out_nbytes), .out_last(s_out_last),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .fifo_count(s_fifo_count),
        .afull(s_afull)
    );

    always #5 clk = ~clk;

    // Stream model: bytes queue up; every NB bytes form a word; a flush emits whatever remains.
    task automatic model_accept(input logic [31:0] d, input int nn, input bit v, input bit f);
        int   n;
        bit   full_done;
        exp_t e;
        n = v ? ((nn > 4) ? 4 : nn) : 0;
        for (int j = 0; j < n; j++) pend.push_back(d[8*j +: 8]);
        full_done = 0;
        if (pend.size() >= 4) begin
            e.d = 32'h0;
            for (int k = 0; k < 4; k++) e.d[8*k +: 8] = pend.pop_front();
            e.nb = 4;
            e.last = f && (pend.size() == 0);
            exp_q.push_back(e);
            full_done = 1;
        end
        if (f && !(full_done && pend.size() == 0)) begin
            e.d = 32'h0;
            e.nb = pend.size();
            for (int k = 0; k < e.nb; k++) e.d[8*k +: 8] = pend.pop_front();
            e.last = 1;
            exp_q.push_back(e);
        end
    endtask

    // Present one beat/flush, wait (bounded) for acceptance, then release the inputs.
    task automatic drive(input logic [31:0] d, input int n, input bit v, input bit f);
        int g = 0;
        @(negedge clk);
        in_data = d; in_nbytes = 3'(n); in_valid = v; in_flush = f;
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL drive_timeout: in_ready stayed %0b, required 1", in_ready);
        end else begin
            model_accept(d, n, v, f);
        end
        @(posedge clk);
        #1;
        in_valid = 0; in_flush = 0;
    endtask

    // Wait (bounded) for a head word, capture it, and pop it.
    task automatic pop_word(output logic [31:0] d, output int nb, output bit last, output bit ok);
        int g = 0;
        @(negedge clk);
        while (!out_valid && g < 100) begin
            @(negedge clk);
            g++;
        end
        ok = out_valid; d = out_data; nb = int'(out_nbytes); last = out_last;
        if (ok) begin
            out_ready = 1;
            @(posedge clk);
            #1;
            out_ready = 0;
        end
    endtask

    task automatic do_reset;
        rstN = 0;
        in_data = 0; in_nbytes = 0; in_valid = 0; in_flush = 0; out_ready = 0;
        s_in_data = 0; s_in_nbytes = 0; s_in_valid = 0; s_in_flush = 0; s_out_ready = 0;
        exp_q.delete(); pend.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstN = 1;
    endtask

    task automatic test_reset;
        rstN = 0;
        in_data = 0; in_nbytes = 0; in_valid = 0; in_flush = 0; out_ready = 0;
        s_in_data = 0; s_in_nbytes = 0; s_in_valid = 0; s_in_flush = 0; s_out_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_nbytes !== 3'd0) begin failures++; $display("FAIL reset_out_nbytes got=%0d exp=0", out_nbytes); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        checks++; if (fifo_count !== 4'd0) begin failures++; $display("FAIL reset_fifo_count got=%0d exp=0", fifo_count); end
        checks++; if (afull !== 1'b0) begin failures++; $display("FAIL reset_afull got=%b exp=0", afull); end
        rstN = 1;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_full_words;
        logic [31:0] d, e;
        int nb;
        bit last, ok;
        for (int b = 0; b < 4; b++) begin
            d = 32'h0;
            for (int k = 0; k < 3; k++) d[8*k +: 8] = 8'(3*b + k + 1);
            drive(d, 3, 1, 0);
        end
        @(negedge clk);
        checks++; if (fifo_count !== 4'd3) begin failures++; $display("FAIL full_count got=%0d exp=3", fifo_count); end
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 4; k++) e[8*k +: 8] = 8'(4*w + k + 1);
            pop_word(d, nb, last, ok);
            checks++;
            if (!ok || d !== e || nb != 4 || last !== 1'b0) begin
                failures++;
                $display("FAIL full_word%0d got=%h/%0d/%b exp=%h/4/0 ok=%b", w, d, nb, last, e, ok);
            end
        end
        @(negedge clk);
        checks++; if (fifo_count !== 4'd0) begin failures++; $display("FAIL full_drained got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_flush_partial;
        logic [31:0] d;
        int nb;
        bit last, ok;
        drive(32'h00030201, 3, 1, 0);
        drive(32'h0, 0, 0, 1);
        pop_word(d, nb, last, ok);
        checks++;
        if (!ok || d !== 32'h00030201 || nb != 3 || last !== 1'b1) begin
            failures++;
            $display("FAIL flush_partial got=%h/%0d/%b exp=00030201/3/1 ok=%b", d, nb, last, ok);
        end
    endtask

    task automatic test_tail;
        logic [31:0] d;
        int nb;
        bit last, ok;
        drive(32'h00030201, 3, 1, 0);
        drive(32'h07060504, 4, 1, 1);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL tail_ready_low got=%b exp=0", in_ready); end
        checks++; if (fifo_count !== 4'd1) begin failures++; $display("FAIL tail_count1 got=%0d exp=1", fifo_count); end
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL tail_ready_back got=%b exp=1", in_ready); end
        checks++; if (fifo_count !== 4'd2) begin failures++; $display("FAIL tail_count2 got=%0d exp=2", fifo_count); end
        pop_word(d, nb, last, ok);
        checks++;
        if (!ok || d !== 32'h04030201 || nb != 4 || last !== 1'b0) begin
            failures++;
            $display("FAIL tail_word0 got=%h/%0d/%b exp=04030201/4/0 ok=%b", d, nb, last, ok);
        end
        pop_word(d, nb, last, ok);
        checks++;
        if (!ok || d !== 32'h00070605 || nb != 3 || last !== 1'b1) begin
            failures++;
            $display("FAIL tail_word1 got=%h/%0d/%b exp=00070605/3/1 ok=%b", d, nb, last, ok);
        end
    endtask

    task automatic test_marker;
        logic [31:0] d;
        int nb;
        bit last, ok;
        drive(32'hDEADBEEF, 0, 1, 0);
        @(negedge clk);
        checks++; if (fifo_count !== 4'd0) begin failures++; $display("FAIL zero_beat_count got=%0d exp=0", fifo_count); end
        drive(32'h0, 0, 0, 1);
        pop_word(d, nb, last, ok);
        checks++;
        if (!ok || d !== 32'h0 || nb != 0 || last !== 1'b1) begin
            failures++;
            $display("FAIL marker got=%h/%0d/%b exp=00000000/0/1 ok=%b", d, nb, last, ok);
        end
    endtask

    task automatic test_swap;
        @(negedge clk);
        s_in_data = 32'h04030201; s_in_nbytes = 3'd4; s_in_valid = 1;
        @(posedge clk);
        #1;
        checks++;
        if (s_out_valid !== 1'b1 || s_out_data !== 32'h01020304 || s_out_nbytes !== 3'd4 || s_out_last !== 1'b0) begin
            failures++;
            $display("FAIL swap_full got=%h/%0d/%b v=%b exp=01020304/4/0 v=1", s_out_data, s_out_nbytes, s_out_last, s_out_valid);
        end
        @(negedge clk);
        s_in_data = 32'h000A0B0C; s_in_nbytes = 3'd3; s_in_flush = 1; s_out_ready = 1;
        @(posedge clk);
        #1;
        s_in_valid = 0; s_in_flush = 0;
        checks++;
        if (s_out_data !== 32'h0C0B0A00 || s_out_nbytes !== 3'd3 || s_out_last !== 1'b1 || s_fifo_count !== 4'd1) begin
            failures++;
            $display("FAIL swap_partial got=%h/%0d/%b cnt=%0d exp=0C0B0A00/3/1 cnt=1", s_out_data, s_out_nbytes, s_out_last, s_fifo_count);
        end
        @(posedge clk);
        #1;
        s_out_ready = 0;
        checks++;
        if (s_out_valid !== 1'b0 || s_fifo_count !== 4'd0) begin
            failures++;
            $display("FAIL swap_drain got v=%b cnt=%0d exp v=0 cnt=0", s_out_valid, s_fifo_count);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] d, e;
        int nb, acc;
        bit last, ok;
        acc = 0;
        out_ready = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            checks++; if (int'(fifo_count) != acc) begin failures++; $display("FAIL bp_count c%0d got=%0d exp=%0d", cyc, fifo_count, acc); end
            checks++; if (in_ready !== (acc <= 6)) begin failures++; $display("FAIL bp_ready c%0d got=%b exp=%b", cyc, in_ready, acc <= 6); end
            checks++; if (afull !== (acc >= 5)) begin failures++; $display("FAIL bp_afull c%0d got=%b exp=%b", cyc, afull, acc >= 5); end
            for (int k = 0; k < 4; k++) in_data[8*k +: 8] = 8'(4*acc + k + 16);
            in_nbytes = 3'd4; in_valid = 1; in_flush = 0;
            if (acc <= 6) acc++;
        end
        @(negedge clk);
        in_valid = 0;
        checks++; if (fifo_count !== 4'd7) begin failures++; $display("FAIL bp_full got=%0d exp=7", fifo_count); end
        for (int w = 0; w < 7; w++) begin
            for (int k = 0; k < 4; k++) e[8*k +: 8] = 8'(4*w + k + 16);
            pop_word(d, nb, last, ok);
            checks++;
            if (!ok || d !== e || nb != 4 || last !== 1'b0) begin
                failures++;
                $display("FAIL bp_word%0d got=%h/%0d/%b exp=%h/4/0 ok=%b", w, d, nb, last, e, ok);
            end
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || fifo_count !== 4'd0 || afull !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_restore got rdy=%b cnt=%0d af=%b v=%b exp rdy=1 cnt=0 af=0 v=0", in_ready, fifo_count, afull, out_valid);
        end
    endtask

    task automatic test_reset_in_tail;
        logic [31:0] d;
        int nb;
        bit last, ok;
        drive(32'h00030201, 3, 1, 0);
        drive(32'h07060504, 4, 1, 1);
        rstN = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_nbytes !== 3'd0 || out_last !== 1'b0 ||
            fifo_count !== 4'd0 || afull !== 1'b0) begin
            failures++;
            $display("FAIL tail_reset got v=%b d=%h nb=%0d l=%b cnt=%0d af=%b exp all 0",
                     out_valid, out_data, out_nbytes, out_last, fifo_count, afull);
        end
        @(negedge clk);
        @(negedge clk);
        rstN = 1;
        exp_q.delete(); pend.delete();
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || fifo_count !== 4'd0) begin
            failures++;
            $display("FAIL tail_reset_release got rdy=%b cnt=%0d exp rdy=1 cnt=0", in_ready, fifo_count);
        end
        drive(32'h44332211, 4, 1, 0);
        pop_word(d, nb, last, ok);
        checks++;
        if (!ok || d !== 32'h44332211 || nb != 4 || last !== 1'b0) begin
            failures++;
            $display("FAIL tail_reset_repack got=%h/%0d/%b exp=44332211/4/0 ok=%b", d, nb, last, ok);
        end
    endtask

    task automatic test_random;
        bit done;
        do_reset();
        done = 0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    int r;
                    r = $urandom_range(0, 9);
                    drive($urandom, $urandom_range(0, 7), r >= 2, (r == 1) || (r >= 8));
                end
                done = 1;
            end
            begin
                int   cyc;
                exp_t e;
                cyc = 0;
                while (!(done && exp_q.size() == 0) && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            failures++;
                            $display("FAIL rand_extra got=%h/%0d/%b exp no word", out_data, out_nbytes, out_last);
                        end else begin
                            e = exp_q.pop_front();
                            if (out_data !== e.d || int'(out_nbytes) != e.nb || out_last !== e.last) begin
                                failures++;
                                $display("FAIL rand_word got=%h/%0d/%b exp=%h/%0d/%b",
                                         out_data, out_nbytes, out_last, e.d, e.nb, e.last);
                            end
                        end
                    end
                end
                if (cyc >= 20000) begin
                    checks++; failures++;
                    $display("FAIL rand_timeout got %0d words pending exp 0", exp_q.size());
                end
            end
        join
        @(negedge clk);
        out_ready = 0;
        checks++;
        if (fifo_count !== 4'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rand_leftover got cnt=%0d v=%b exp cnt=0 v=0", fifo_count, out_valid);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_words();
        test_flush_partial();
        test_tail();
        test_marker();
        test_swap();
        test_backpressure();
        test_reset_in_tail();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/byte_pack_glue.md
BYTE_PACK_GLUE -- requirements
Module: byte_pack_glue

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  NB, 4, bytes per word (2..16).
  DEPTH, 512, output FIFO entries (power of 2, >=4).
  AFULL_LVL, 256, almost-full threshold in entries.
  SWAP, 0, 1 = output lane order reversed (big-endian).
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk  in  1  clock
  rstN  in  1  reset, asynchronous active-low
  in_data  in  8*NB  input bytes; lane 0 (bits 7:0) = first in stream
  in_nbytes  in  clog2(NB+1)  valid bytes, lanes 0..in_nbytes-1
  in_valid  in  1  beat present
  in_flush  in  1  end of segment; emit partial word, mark last
  in_ready  out  1  beat/flush accepted when high with in_valid or in_flush
  out_data  out  8*NB  packed word
  out_nbytes  out  clog2(NB+1)  valid bytes in out_data (NB = full)
  out_last  out  1  final word of segment
  out_valid  out  1  FIFO non-empty (first-word-fall-through)
  out_ready  in  1  pop when out_valid && out_ready
  fifo_count  out  clog2(DEPTH+1)  entries held
  afull  out  1  fifo_count >= AFULL_LVL
REQ-003 Single clock clk; reset rstN is asynchronous, active-low.

Function
REQ-004 Accumulator holds 2*NB-1 bytes plus a level register; the level is < NB at every clock edge.
REQ-005 Accepted beat appends in_nbytes bytes, in lane order, after the current level.
REQ-006 in_nbytes > NB is treated as NB; in_nbytes = 0 without flush has no effect.
REQ-007 When level+n >= NB, the lowest NB bytes are pushed to the FIFO the same edge; the remainder shifts down; at most one push per cycle.
REQ-008 Output lane k = stream byte k when SWAP=0, and stream byte NB-1-k when SWAP=1.
REQ-009 FSM states RUN and TAIL; reset state is RUN.
REQ-010 Flush with no beat, or with a beat not completing a word: push one word, out_nbytes = resulting level (0..NB-1), out_last=1, unused lanes zero; clear level; stay RUN.
REQ-011 Flush with a beat completing a word and leftover > 0: push the full word with last=0; go to TAIL.
REQ-012 Flush with a beat completing a word and leftover = 0: push the full word with last=1; stay RUN.
REQ-013 TAIL: push the leftover word with out_nbytes = level and last=1; clear level; return to RUN next cycle. in_ready=0 while in TAIL.
REQ-014 Flush with level 0 and no beat bytes: push a marker word, out_nbytes=0, out_last=1, data zero.
REQ-015 in_ready = (state==RUN) && fifo_count <= DEPTH-2, guaranteeing room for full word plus tail; FIFO never overflows, no write is dropped.
REQ-016 Inputs are ignored when in_ready=0; the source holds them.
REQ-017 Latency: a word pushed at edge N is on out_data with out_valid=1 after edge N if the FIFO was empty.
REQ-018 Simultaneous push and pop leaves fifo_count unchanged; pop from an empty FIFO is ignored.
REQ-019 afull and fifo_count are registered and consistent with FIFO contents after each edge.

Reset
REQ-020 rstN low, at any time including TAIL: FIFO empty, level 0, state RUN, out_valid 0, out_data 0, out_nbytes 0, out_last 0, fifo_count 0, afull 0; in_ready=1 on the first edge after release.

Verification (NB=4, SWAP=0 unless stated)
REQ-021 Four 3-byte beats, bytes 01..0C -> three words 0x04030201, 0x08070605, 0x0C0B0A09, nbytes=4, last=0.
REQ-022 3-byte beat 01 02 03, then flush alone -> one word 0x00030201, nbytes=3, last=1.
REQ-023 Beat 01 02 03, then 4-byte beat 04..07 with flush -> 0x04030201 last=0; next cycle 0x00070605 nbytes=3 last=1; in_ready low exactly one cycle.
REQ-024 Flush with empty accumulator -> marker word, nbytes=0, last=1. SWAP=1 with beat 01..04 -> 0x01020304.
REQ-025 DEPTH=8, out_ready=0, continuous 4-byte beats -> in_ready falls when fifo_count=7; afull tracks AFULL_LVL; draining with out_ready=1 restores in_ready; no data lost or duplicated.
REQ-026 rstN pulsed while in TAIL -> all outputs at reset values; the subsequent stream packs from level 0.
